// File: rtl/vram_cpu_port_if.sv
// Bus bundle between the Z80 decode, vram_cpu_port and the tile generator CPU port.
// slave = vram_cpu_port view, master = surrounding environment view.
interface vram_cpu_port_if;
   // Handshake: a request is a decoded tile-window hit held on the CPU strobes;
   // it completes in the cycle cpu_wait_n is high while the hit is still present.
   logic       cpu_mreq_n;
   logic       cpu_rd_n;
   logic       cpu_wr_n;
   logic [15:0] cpu_addr;
   logic [7:0] cpu_dout;
   logic [7:0] cpu_din;
   logic       cpu_sel;
   logic       cpu_wait_n;
   logic       cmpblk;
   logic       vram_busy;
   logic       vram_rdn;
   logic       vram_wrn;
   logic       vram_tile_ena;
   logic [9:0] vram_addr;
   logic [7:0] vram_din;
   logic [7:0] vram_dout;
   logic       wait_err;

   modport slave (
      input  cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_addr, cpu_dout,
      input  cmpblk, vram_busy, vram_dout,
      output cpu_din, cpu_sel, cpu_wait_n,
      output vram_rdn, vram_wrn, vram_tile_ena, vram_addr, vram_din, wait_err
   );

   modport master (
      output cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_addr, cpu_dout,
      output cmpblk, vram_busy, vram_dout,
      input  cpu_din, cpu_sel, cpu_wait_n,
      input  vram_rdn, vram_wrn, vram_tile_ena, vram_addr, vram_din, wait_err
   );
endinterface

// File: rtl/vram_cpu_port.sv
// Z80 initiator into tile RAM: decode, WAIT until the tile generator frees RAM, strobe, capture.
// Optional macro VRAM_POST_WRITE_EN: writes are acknowledged at once and committed in the background.
module vram_cpu_port #(
   parameter logic [5:0]  BASE_HI  = 6'b011101,
   parameter int unsigned MAX_WAIT = 1023
) (
   input  logic            clk,
   input  logic            rst_n,
   vram_cpu_port_if.slave  bus,
   output logic [1:0]      dbg_state_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, CAPT = 2'd2} state_t;

   localparam logic [9:0] WAIT_LIM = 10'(MAX_WAIT - 1);

   state_t     state_q, state_d;
   logic       ack_q, ack_d;
   logic       rd_q, rd_d;
   logic [9:0] addr_q, addr_d;
   logic [7:0] din_q, din_d;
   logic [7:0] cpu_din_q, cpu_din_d;
   logic [9:0] cnt_q, cnt_d;
   logic       err_q, err_d;
   logic       rdn_s, wrn_s, tena_s;
   logic       hit, is_rd, window, post_accept;

   assign is_rd  = ~bus.cpu_rd_n;
   assign hit    = ~bus.cpu_mreq_n & (~bus.cpu_rd_n | ~bus.cpu_wr_n)
                   & (bus.cpu_addr[15:10] == BASE_HI);
   assign window = bus.cmpblk & ~bus.vram_busy;

`ifdef VRAM_POST_WRITE_EN
   assign post_accept = (state_q == IDLE) & hit & ~is_rd & ~ack_q;
`else
   assign post_accept = 1'b0;
`endif

   // WAIT is released while in reset so a reset mid-access never stalls the CPU.
   assign bus.cpu_wait_n    = ~rst_n | ~hit | ack_q | post_accept;
   assign bus.cpu_sel       = hit & is_rd & ack_q;
   assign bus.cpu_din       = cpu_din_q;
   assign bus.vram_addr     = addr_q;
   assign bus.vram_din      = din_q;
   assign bus.vram_rdn      = rdn_s;
   assign bus.vram_wrn      = wrn_s;
   assign bus.vram_tile_ena = tena_s;
   assign bus.wait_err      = err_q;
   assign dbg_state_o       = state_q;

   always_comb begin
      state_d   = state_q;
      ack_d     = ack_q & hit;
      rd_d      = rd_q;
      addr_d    = addr_q;
      din_d     = din_q;
      cpu_din_d = cpu_din_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      rdn_s     = 1'b1;
      wrn_s     = 1'b1;
      tena_s    = 1'b0;
      case (state_q)
         IDLE: begin
            if (hit && !ack_q) begin
               addr_d  = bus.cpu_addr[9:0];
               din_d   = bus.cpu_dout;
               rd_d    = is_rd;
               cnt_d   = 10'd0;
               state_d = PEND;
               if (post_accept) ack_d = 1'b1;
            end
         end
         PEND: begin
            if (cnt_q != 10'h3FF) cnt_d = cnt_q + 10'd1;
            if (cnt_q >= WAIT_LIM) err_d = 1'b1;
            if (window) begin
               if (rd_q) begin
                  rdn_s   = 1'b0;
                  state_d = CAPT;
               end else begin
                  wrn_s   = 1'b0;
                  tena_s  = 1'b1;
                  state_d = IDLE;
`ifndef VRAM_POST_WRITE_EN
                  ack_d   = hit;
`endif
               end
            end
         end
         CAPT: begin
            // Tile RAM presents read data one cycle after the strobe.
            cpu_din_d = bus.vram_dout;
            ack_d     = hit;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ack_q     <= 1'b0;
         rd_q      <= 1'b0;
         addr_q    <= 10'h000;
         din_q     <= 8'h00;
         cpu_din_q <= 8'h00;
         cnt_q     <= 10'd0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ack_q     <= ack_d;
         rd_q      <= rd_d;
         addr_q    <= addr_d;
         din_q     <= din_d;
         cpu_din_q <= cpu_din_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_vram_cpu_port.sv
// Self-checking bench for vram_cpu_port: directed cases then randomized accesses
// checked against a transaction-level latency/data model.
module tb_vram_cpu_port;

   localparam logic [5:0] BASE_HI  = 6'b011101;
   localparam int         MAX_WAIT = 8;
`ifdef VRAM_POST_WRITE_EN
   localparam bit POST = 1'b1;
`else
   localparam bit POST = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] dbg_state;
   int         n_vec = 0;
   int         n_err = 0;
   bit         err_model = 1'b0;

   vram_cpu_port_if bus ();

   vram_cpu_port #(.BASE_HI(BASE_HI), .MAX_WAIT(MAX_WAIT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_idle();
      bus.cpu_mreq_n = 1'b1;
      bus.cpu_rd_n   = 1'b1;
      bus.cpu_wr_n   = 1'b1;
   endtask

   task automatic drive_cpu(input bit rd, input logic [15:0] a, input logic [7:0] d);
      bus.cpu_mreq_n = 1'b0;
      bus.cpu_rd_n   = ~rd;
      bus.cpu_wr_n   = rd;
      bus.cpu_addr   = a;
      bus.cpu_dout   = d;
   endtask

   task automatic set_win(input bit open, input bit busy_only);
      if (open) begin
         bus.cmpblk = 1'b1; bus.vram_busy = 1'b0;
      end else if (busy_only) begin
         bus.cmpblk = 1'b1; bus.vram_busy = 1'b1;
      end else begin
         case ($urandom_range(0, 2))
            0:       begin bus.cmpblk = 1'b0; bus.vram_busy = 1'b0; end
            1:       begin bus.cmpblk = 1'b0; bus.vram_busy = 1'b1; end
            default: begin bus.cmpblk = 1'b1; bus.vram_busy = 1'b1; end
         endcase
      end
   endtask

   // One CPU access; window first opens k cycles after the hit is seen.
   task automatic run_txn(input bit is_rd, input logic [15:0] a, input logic [7:0] d,
                          input int k, input bit busy_only, input bit err_tl, input int fixed_dout);
      logic       win [64];
      logic [7:0] dout_v [64];
      int         tlen, kk, wait_low, n_rd, n_wr, s_cyc, exp_low;
      logic [9:0] s_addr;
      logic [7:0] s_din, fin_din;
      bit         done, te_ok, sel_early, fin_sel;
      tlen = k + 4; kk = -1; wait_low = 0; n_rd = 0; n_wr = 0; s_cyc = -1;
      s_addr = '0; s_din = '0; fin_din = '0; fin_sel = 1'b0;
      done = 1'b0; te_ok = 1'b1; sel_early = 1'b0;
      for (int c = 0; c < 64; c++) begin
         win[c]    = (c == k) ? 1'b1 : ((c >= 1 && c < k) ? 1'b0 : 1'($urandom_range(0, 1)));
         dout_v[c] = (fixed_dout >= 0) ? 8'(fixed_dout) : 8'($urandom);
      end
      for (int c = 1; c < 64; c++)
         if (kk < 0 && win[c]) kk = c;
      exp_low = is_rd ? kk + 2 : (POST ? 0 : kk + 1);
      if (kk >= MAX_WAIT) err_model = 1'b1;
      for (int c = 0; c < tlen; c++) begin
         @(negedge clk);
         if (done) drive_idle(); else drive_cpu(is_rd, a, d);
         set_win(win[c], busy_only);
         bus.vram_dout = dout_v[c];
         #2;
         if (!done) begin
            if (!bus.cpu_wait_n) begin
               wait_low++;
               if (bus.cpu_sel) sel_early = 1'b1;
            end else begin
               done = 1'b1; fin_din = bus.cpu_din; fin_sel = bus.cpu_sel;
            end
         end
         if (!bus.vram_rdn) begin n_rd++; s_cyc = c; s_addr = bus.vram_addr; end
         if (!bus.vram_wrn) begin
            n_wr++; s_cyc = c; s_addr = bus.vram_addr; s_din = bus.vram_din;
            if (!bus.vram_tile_ena) te_ok = 1'b0;
         end else if (bus.vram_tile_ena) te_ok = 1'b0;
         if (err_tl && c >= 1) chk("wait_err_timeline", 16'(bus.wait_err), 16'(c >= MAX_WAIT + 1));
      end
      chk("completed", 16'(done), 16'd1);
      chk("wait_cycles", 16'(wait_low), 16'(exp_low));
      chk("rd_strobes", 16'(n_rd), is_rd ? 16'd1 : 16'd0);
      chk("wr_strobes", 16'(n_wr), is_rd ? 16'd0 : 16'd1);
      chk("strobe_cycle", 16'(s_cyc), 16'(kk));
      chk("strobe_addr", 16'(s_addr), 16'(a[9:0]));
      chk("tile_ena", 16'(te_ok), 16'd1);
      chk("sel_early", 16'(sel_early), 16'd0);
      chk("sel_final", 16'(fin_sel), 16'(is_rd));
      if (is_rd) chk("rd_data", 16'(fin_din), 16'(dout_v[kk + 1]));
      else       chk("wr_data", 16'(s_din), 16'(d));
      chk("wait_err", 16'(bus.wait_err), 16'(err_model));
   endtask

   task automatic run_miss(input string tag, input logic [15:0] a, input bit mreq_n,
                           input bit rd_n, input bit wr_n);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         bus.cpu_mreq_n = mreq_n; bus.cpu_rd_n = rd_n; bus.cpu_wr_n = wr_n;
         bus.cpu_addr = a; bus.cpu_dout = 8'($urandom);
         set_win(1'b1, 1'b0);
         #2;
         chk({tag, "_wait_n"}, 16'(bus.cpu_wait_n), 16'd1);
         chk({tag, "_rdn"}, 16'(bus.vram_rdn), 16'd1);
         chk({tag, "_wrn"}, 16'(bus.vram_wrn), 16'd1);
      end
      @(negedge clk);
      drive_idle();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_wait_n"}, 16'(bus.cpu_wait_n), 16'd1);
      chk({tag, "_rdn"}, 16'(bus.vram_rdn), 16'd1);
      chk({tag, "_wrn"}, 16'(bus.vram_wrn), 16'd1);
      chk({tag, "_tile_ena"}, 16'(bus.vram_tile_ena), 16'd0);
      chk({tag, "_vram_addr"}, 16'(bus.vram_addr), 16'h000);
      chk({tag, "_vram_din"}, 16'(bus.vram_din), 16'h00);
      chk({tag, "_cpu_din"}, 16'(bus.cpu_din), 16'h00);
      chk({tag, "_cpu_sel"}, 16'(bus.cpu_sel), 16'd0);
      chk({tag, "_wait_err"}, 16'(bus.wait_err), 16'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      drive_cpu(1'b1, 16'h7405, 8'h00);
      bus.cmpblk = 1'b1; bus.vram_busy = 1'b0; bus.vram_dout = 8'h00;

      // Reset values with an in-window read held on the bus.
      repeat (2) @(negedge clk);
      #2;
      chk_reset_vals("por");
      @(negedge clk);
      drive_idle();
      rst_n = 1'b1;
      @(negedge clk);

      // Read 7405h with window open, data 5Ah.
      run_txn(1'b1, 16'h7405, 8'h00, 1, 1'b0, 1'b0, 8'h5A);

      // Accesses outside the tile window or without a strobe.
      run_miss("miss_7800", 16'h7800, 1'b0, 1'b0, 1'b1);
      run_miss("miss_73FF", 16'h73FF, 1'b0, 1'b1, 1'b0);
      run_miss("no_mreq", 16'h7405, 1'b1, 1'b0, 1'b1);
      run_miss("no_strobe", 16'h7405, 1'b0, 1'b1, 1'b1);

      // Window closed 12 pend cycles: wait_err timeline.
      run_txn(1'b1, 16'h7400 | 16'($urandom_range(0, 1023)), 8'h00, 13, 1'b0, 1'b1, -1);

      // Write 77FFh/C3h with vram_busy high for 20 cycles.
      run_txn(1'b0, 16'h77FF, 8'hC3, 21, 1'b1, 1'b0, -1);

      // Reset while a write is pending: no strobe ever, write discarded.
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c < 7) drive_cpu(1'b0, 16'h7412, 8'h99); else drive_idle();
         set_win(c >= 4, 1'b0);
         if (c == 3) rst_n = 1'b0;
         if (c == 7) rst_n = 1'b1;
         #2;
         if (c == 3) chk_reset_vals("mid_rst");
         if (c >= 3) begin
            chk("rst_rdn", 16'(bus.vram_rdn), 16'd1);
            chk("rst_wrn", 16'(bus.vram_wrn), 16'd1);
            chk("rst_wait_n", 16'(bus.cpu_wait_n), 16'd1);
         end
      end
      err_model = 1'b0;
      chk("post_rst_wait_err", 16'(bus.wait_err), 16'd0);

      // Randomized accesses.
      for (int t = 0; t < 40; t++) begin
         run_txn(1'($urandom_range(0, 1)), {BASE_HI, 10'($urandom)}, 8'($urandom),
                 $urandom_range(1, 9), 1'($urandom_range(0, 1)), 1'b0, -1);
      end

`ifdef VRAM_POST_WRITE_EN
      // Posted write with window closed, then an immediate read.
      begin
         int rd_low, wr_cyc, rd_cyc;
         logic [7:0] pv [16];
         bit wr_wait_hi, rd_done;
         logic [7:0] got;
         rd_low = 0; wr_cyc = -1; rd_cyc = -1; wr_wait_hi = 1'b0; rd_done = 1'b0; got = '0;
         for (int c = 0; c < 16; c++) pv[c] = 8'($urandom);
         for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c == 0) drive_cpu(1'b0, 16'h7420, 8'hA5);
            else if (c >= 2 && !rd_done) drive_cpu(1'b1, 16'h7421, 8'h00);
            else drive_idle();
            set_win(c >= 5, 1'b0);
            bus.vram_dout = pv[c];
            #2;
            if (c == 0) wr_wait_hi = bus.cpu_wait_n;
            if (c >= 2 && !rd_done) begin
               if (!bus.cpu_wait_n) rd_low++;
               else begin rd_done = 1'b1; got = bus.cpu_din; end
            end
            if (!bus.vram_wrn) wr_cyc = c;
            if (!bus.vram_rdn) rd_cyc = c;
         end
         chk("post_wr_no_wait", 16'(wr_wait_hi), 16'd1);
         chk("post_wr_strobe", 16'(wr_cyc), 16'd5);
         chk("post_rd_strobe", 16'(rd_cyc), 16'd7);
         chk("post_rd_wait", 16'(rd_low), 16'd7);
         chk("post_rd_data", 16'(got), 16'(pv[8]));
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
